// File: rtl/sale_pkg.sv
// sale_pkg: shared state encoding, default prices/limits and saturating add for the sale controller
package sale_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        PAY      = 3'd2,
        DISPENSE = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0] DEF_PRICE1      = 8'd4;
    localparam logic [7:0] DEF_PRICE2      = 8'd9;
    localparam logic [7:0] DEF_PRICE3      = 8'd13;
    localparam logic [7:0] DEF_PRICE4      = 8'd17;
    localparam logic [3:0] DEF_MAX_QTY     = 4'd9;
    localparam int         DEF_TIMEOUT_CYC = 50;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hff : s[7:0];
    endfunction

endpackage

// File: rtl/sale_controller_timer.sv
// sale_timer: inactivity counter; cleared while not running or on restart, expire after CYC quiet cycles
module sale_timer #(
    parameter int CYC = 50
) (
    input  logic clkout1,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expire
);

    localparam int W = $clog2(CYC + 1);

    logic [W-1:0] cnt;

    assign expire = run && !restart && (cnt == W'(CYC - 1));

    // count quiet cycles while the purchase is waiting on the customer
    always_ff @(posedge clkout1) begin
        if (!rst || !run || restart)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sale_controller.sv
// sale_controller: customer purchase FSM with stock/sold/revenue counters; optional auto-cancel under TIMEOUT_EN
module sale_controller
    import sale_pkg::*;
#(
`ifdef TIMEOUT_EN
    parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
`endif
    parameter logic [7:0] PRICE1      = DEF_PRICE1,
    parameter logic [7:0] PRICE2      = DEF_PRICE2,
    parameter logic [7:0] PRICE3      = DEF_PRICE3,
    parameter logic [7:0] PRICE4      = DEF_PRICE4,
    parameter logic [3:0] MAX_QTY     = DEF_MAX_QTY
) (
    input  logic       clkout1,
    input  logic       rst,
    input  logic [3:0] sel,
    input  logic [3:0] key_value,
    input  logic       key_vld,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       rep_load,
    input  logic [7:0] rep_S1_num,
    input  logic [7:0] rep_S2_num,
    input  logic [7:0] rep_S3_num,
    input  logic [7:0] rep_S4_num,
    output logic [7:0] S1_num,
    output logic [7:0] S2_num,
    output logic [7:0] S3_num,
    output logic [7:0] S4_num,
    output logic [7:0] S1_sell,
    output logic [7:0] S2_sell,
    output logic [7:0] S3_sell,
    output logic [7:0] S4_sell,
    output logic [7:0] price_sum,
    output logic [2:0] state_o,
    output logic [7:0] total,
    output logic [7:0] paid,
    output logic [7:0] change,
    output logic       busy,
    output logic       err
);

    state_t          state, state_n;
    logic [1:0]      aisle, aisle_n;
    logic [7:0]      price, price_n;
    logic [3:0]      qty, qty_n;
    logic [7:0]      total_n, paid_n, change_n, sum_n;
    logic [3:0][7:0] stock, stock_n, sell, sell_n;
    logic            err_n;
    logic            expire;
    logic [1:0]      sel_idx;
    logic [7:0]      sel_price;

`ifdef TIMEOUT_EN
    sale_timer #(.CYC(TIMEOUT_CYC)) u_timer (
        .clkout1 (clkout1),
        .rst     (rst),
        .run     (state == SELECT || state == PAY),
        .restart (key_vld | confirm | cancel | rep_load),
        .expire  (expire)
    );
`else
    assign expire = 1'b0;
`endif

    assign sel_idx   = {sel[3] | sel[2], sel[3] | sel[1]};
    assign sel_price = sel[0] ? PRICE1 : sel[1] ? PRICE2 : sel[2] ? PRICE3 : PRICE4;
    assign state_o   = state;
    assign busy      = state != IDLE;
    assign S1_num    = stock[0];
    assign S2_num    = stock[1];
    assign S3_num    = stock[2];
    assign S4_num    = stock[3];
    assign S1_sell   = sell[0];
    assign S2_sell   = sell[1];
    assign S3_sell   = sell[2];
    assign S4_sell   = sell[3];

    // next state and next datapath values; cancel beats confirm beats key_vld
    always_comb begin
        state_n  = state;
        aisle_n  = aisle;
        price_n  = price;
        qty_n    = qty;
        total_n  = total;
        paid_n   = paid;
        change_n = change;
        stock_n  = stock;
        sell_n   = sell;
        sum_n    = price_sum;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (rep_load)
                    stock_n = {rep_S4_num, rep_S3_num, rep_S2_num, rep_S1_num};
                if ($onehot(sel)) begin
                    state_n = SELECT;
                    aisle_n = sel_idx;
                    price_n = sel_price;
                    qty_n   = 4'd1;
                    total_n = sel_price;
                end else if (sel != 4'd0)
                    err_n = 1'b1;
            end
            SELECT: begin
                if (cancel || expire) begin
                    state_n = IDLE;
                    qty_n   = '0;
                    total_n = '0;
                end else if (confirm) begin
                    if ({4'd0, qty} <= stock[aisle])
                        state_n = PAY;
                    else
                        err_n = 1'b1;
                end else if (key_vld) begin
                    if (key_value != 4'd0 && key_value <= MAX_QTY) begin
                        qty_n   = key_value;
                        total_n = price * {4'd0, key_value};
                    end else
                        err_n = 1'b1;
                end
            end
            PAY: begin
                if (cancel || expire) begin
                    state_n  = DONE;
                    change_n = paid;
                end else begin
                    if (key_vld && !confirm)
                        paid_n = sat_add8(paid, {4'd0, key_value});
                    if (paid >= total)
                        state_n = DISPENSE;
                end
            end
            DISPENSE: begin
                stock_n[aisle] = stock[aisle] - {4'd0, qty};
                sell_n[aisle]  = sat_add8(sell[aisle], {4'd0, qty});
                sum_n          = sat_add8(price_sum, total);
                change_n       = paid - total;
                state_n        = DONE;
            end
            DONE: begin
                if (confirm && !cancel) begin
                    state_n  = IDLE;
                    qty_n    = '0;
                    total_n  = '0;
                    paid_n   = '0;
                    change_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and datapath registers, cleared by synchronous active-low reset
    always_ff @(posedge clkout1) begin
        if (!rst) begin
            state     <= IDLE;
            aisle     <= '0;
            price     <= '0;
            qty       <= '0;
            total     <= '0;
            paid      <= '0;
            change    <= '0;
            stock     <= '0;
            sell      <= '0;
            price_sum <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            aisle     <= aisle_n;
            price     <= price_n;
            qty       <= qty_n;
            total     <= total_n;
            paid      <= paid_n;
            change    <= change_n;
            stock     <= stock_n;
            sell      <= sell_n;
            price_sum <= sum_n;
            err       <= err_n;
        end
    end

endmodule
